// File: rtl/seq_mult_pkg.sv
// Shared state encoding, default width and counter sizing for the seq_mult multiplier.
package seq_mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY,
    S_DONE = ST_DONE
  } state_e;

  // Iteration counter must be able to hold the value WIDTH itself.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_abs.sv
// Conditional two's-complement negate: used both to take operand magnitudes and to
// restore the sign of the final product.
module seq_mult_abs #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, signed or unsigned.
// Optional early termination when the remaining multiplier is zero: SEQ_MULT_EARLY_EXIT_EN.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = count_width(WIDTH);

  state_e           r_state;
  state_e           w_state_next;
  logic             r_sign;
  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_p;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_count;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [PW-1:0]    w_acc_next;
  logic [PW-1:0]    w_p_final;
  logic [WIDTH-1:0] w_mplier_next;
  logic [CW-1:0]    w_count_next;
  logic             w_last;
  logic             w_accept;

  seq_mult_abs #(.W(WIDTH)) u_abs_a (
    .i_val (a),
    .i_neg (is_signed & a[WIDTH-1]),
    .o_val (w_abs_a)
  );

  seq_mult_abs #(.W(WIDTH)) u_abs_b (
    .i_val (b),
    .i_neg (is_signed & b[WIDTH-1]),
    .o_val (w_abs_b)
  );

  // Sign is restored on the accumulator value including the final iteration's add.
  seq_mult_abs #(.W(PW)) u_abs_p (
    .i_val (w_acc_next),
    .i_neg (r_sign),
    .o_val (w_p_final)
  );

  assign w_accept      = in_valid && (r_state == S_IDLE);
  assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_next = r_mplier >> 1;
  assign w_count_next  = r_count + CW'(1);

`ifdef SEQ_MULT_EARLY_EXIT_EN
  assign w_last = (w_count_next == CW'(WIDTH)) || (w_mplier_next == '0);
`else
  assign w_last = (w_count_next == CW'(WIDTH));
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_BUSY;
      S_BUSY:  if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_p      <= '0;
    end else if (w_accept) begin
      r_sign   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
      r_mplier <= w_abs_b;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= w_mplier_next;
      r_count  <= w_count_next;
      if (w_last) r_p <= w_p_final;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign p         = r_p;

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: three instances (WIDTH 4, 8, 16) against an
// integer-arithmetic reference; follows SEQ_MULT_EARLY_EXIT_EN for expected latency.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a_v = '0;
  logic [15:0] b_v = '0;
  logic        sgn = 1'b0;
  logic        out_rdy = 1'b0;
  logic [2:0]  iv = '0;

  logic        ir4, ir8, ir16;
  logic        ov4, ov8, ov16;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [31:0] p16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_mult #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir4), .a(a_v[3:0]), .b(b_v[3:0]),
    .is_signed(sgn), .out_valid(ov4), .out_ready(out_rdy), .p(p4)
  );

  seq_mult #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir8), .a(a_v[7:0]), .b(b_v[7:0]),
    .is_signed(sgn), .out_valid(ov8), .out_ready(out_rdy), .p(p8)
  );

  seq_mult #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir16), .a(a_v), .b(b_v),
    .is_signed(sgn), .out_valid(ov16), .out_ready(out_rdy), .p(p16)
  );

  function automatic int wid(input int idx);
    return (idx == 0) ? 4 : (idx == 1) ? 8 : 16;
  endfunction

  function automatic logic get_ir(input int idx);
    return (idx == 0) ? ir4 : (idx == 1) ? ir8 : ir16;
  endfunction

  function automatic logic get_ov(input int idx);
    return (idx == 0) ? ov4 : (idx == 1) ? ov8 : ov16;
  endfunction

  function automatic logic [31:0] get_p(input int idx);
    return (idx == 0) ? {24'd0, p4} : (idx == 1) ? {16'd0, p8} : p16;
  endfunction

  // Interpret operands as integers and multiply; truncate to 2*w bits.
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] av,
                                          input logic [15:0] bv, input logic s);
    longint m, x, y, pr;
    m = longint'(1) << w;
    x = longint'({48'd0, av}) & (m - 1);
    y = longint'({48'd0, bv}) & (m - 1);
    if (s && x >= m / 2) x = x - m;
    if (s && y >= m / 2) y = y - m;
    pr = x * y;
    return 32'(pr & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic int exp_lat(input int w, input logic [15:0] bv, input logic s);
    longint m, y;
    int l;
    m = longint'(1) << w;
    y = longint'({48'd0, bv}) & (m - 1);
    if (s && y >= m / 2) y = m - y;
    l = 1;
    for (int i = 0; i < w; i++) if (((y >> i) & 1) == 1) l = i + 1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    return l;
`else
    return (l > 0) ? w : w;
`endif
  endfunction

  // Called at a negedge with the chosen DUT idle; returns at the negedge after release.
  task automatic run_job(input int idx, input logic [15:0] av, input logic [15:0] bv,
                         input logic s, input logic [31:0] exp_p, input int stall,
                         input bit noise, input string tag);
    int w, lat, el;
    w  = wid(idx);
    el = exp_lat(w, bv, s);
    total++;
    if (get_ir(idx) !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_before_accept: got %b want 1", tag, get_ir(idx));
    end
    a_v = av; b_v = bv; sgn = s; iv[idx] = 1'b1;
    out_rdy = 1'b0;
    @(negedge clk);
    iv[idx] = 1'b0;
    lat = 0;
    while (get_ov(idx) !== 1'b1 && lat < 100) begin
      if (noise) begin
        a_v = 16'($urandom); b_v = 16'($urandom); sgn = 1'($urandom);
        iv[idx] = 1'($urandom); out_rdy = 1'($urandom);
      end
      total++;
      if (get_ir(idx) !== 1'b0) begin
        bad++;
        $display("FAIL %s ready_while_busy: got %b want 0", tag, get_ir(idx));
      end
      @(negedge clk);
      lat++;
    end
    iv[idx] = 1'b0;
    out_rdy = 1'b0;
    total++;
    if (lat != el) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, el);
    end
    total++;
    if (get_p(idx) !== exp_p) begin
      bad++;
      $display("FAIL %s product a=%h b=%h s=%b: got %h want %h", tag, av, bv, s, get_p(idx), exp_p);
    end
    repeat (stall) begin
      @(negedge clk);
      total++;
      if (get_ov(idx) !== 1'b1 || get_ir(idx) !== 1'b0 || get_p(idx) !== exp_p) begin
        bad++;
        $display("FAIL %s hold: got ov=%b ir=%b p=%h want ov=1 ir=0 p=%h",
                 tag, get_ov(idx), get_ir(idx), get_p(idx), exp_p);
      end
    end
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    total++;
    if (get_ov(idx) !== 1'b0 || get_ir(idx) !== 1'b1) begin
      bad++;
      $display("FAIL %s release: got ov=%b ir=%b want ov=0 ir=1", tag, get_ov(idx), get_ir(idx));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (get_ir(i) !== 1'b1 || get_ov(i) !== 1'b0 || get_p(i) !== 32'd0) begin
        bad++;
        $display("FAIL reset w%0d: got ir=%b ov=%b p=%h want ir=1 ov=0 p=0",
                 wid(i), get_ir(i), get_ov(i), get_p(i));
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_job(1, 16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01, 0, 1'b0, "u255x255");
    run_job(1, 16'h0080, 16'h0080, 1'b1, 32'h00004000, 0, 1'b0, "s80x80");
    run_job(1, 16'h00FD, 16'h0005, 1'b1, 32'h0000FFF1, 0, 1'b0, "sm3x5");
    run_job(1, 16'h0080, 16'h0001, 1'b1, 32'h0000FF80, 0, 1'b0, "s80x01");
    run_job(1, 16'h00C8, 16'h0001, 1'b0, 32'h000000C8, 0, 1'b0, "u200x1");
    run_job(1, 16'h005A, 16'h0000, 1'b0, 32'h00000000, 0, 1'b0, "bzero");
    run_job(1, 16'h0003, 16'h0080, 1'b0, 32'h00000180, 0, 1'b0, "b80u");
    run_job(1, 16'h0005, 16'h00FF, 1'b1, 32'h0000FFFB, 0, 1'b0, "s5xm1");
    run_job(0, 16'h0008, 16'h0008, 1'b1, 32'h00000040, 0, 1'b0, "w4_min2");
    run_job(0, 16'h000F, 16'h000F, 1'b0, 32'h000000E1, 0, 1'b0, "w4_max2");
    run_job(2, 16'h8000, 16'h8000, 1'b1, 32'h40000000, 0, 1'b0, "w16_min2");
    run_job(2, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0, 1'b0, "w16_max2");
  endtask

  task automatic test_backpressure();
    run_job(1, 16'h0012, 16'h0034, 1'b0, 32'h000003A8, 5, 1'b0, "bp5");
  endtask

  task automatic test_reset_mid_busy();
    a_v = 16'h00FF; b_v = 16'h00FF; sgn = 1'b0; iv[1] = 1'b1;
    @(negedge clk);
    iv[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || p8 !== 16'd0) begin
      bad++;
      $display("FAIL abort_reset: got ir=%b ov=%b p=%h want ir=1 ov=0 p=0", ir8, ov8, p8);
    end
    rst = 1'b0;
    @(negedge clk);
    run_job(1, 16'h0007, 16'h0009, 1'b0, 32'd63, 0, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    run_job(1, 16'h00F0, 16'h000F, 1'b1, ref_mul(8, 16'h00F0, 16'h000F, 1'b1), 0, 1'b1, "b2b0");
    run_job(1, 16'h007F, 16'h0081, 1'b1, ref_mul(8, 16'h007F, 16'h0081, 1'b1), 0, 1'b1, "b2b1");
    run_job(1, 16'h0011, 16'h0022, 1'b0, ref_mul(8, 16'h0011, 16'h0022, 1'b0), 0, 1'b1, "b2b2");
  endtask

  function automatic logic [15:0] pick(input int w);
    logic [15:0] m;
    int r;
    m = 16'((32'd1 << w) - 1);
    r = $urandom_range(0, 9);
    case (r)
      0:       return 16'd0;
      1:       return m;
      2:       return 16'(32'd1 << (w - 1));
      3:       return 16'd1;
      default: return 16'($urandom) & m;
    endcase
  endfunction

  task automatic test_random(input int idx, input int n);
    logic [15:0] ra, rb;
    logic rs;
    int st;
    for (int k = 0; k < n; k++) begin
      ra = pick(wid(idx));
      rb = pick(wid(idx));
      rs = 1'($urandom);
      st = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      run_job(idx, ra, rb, rs, ref_mul(wid(idx), ra, rb, rs), st, 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
    test_random(0, 1500);
    test_random(1, 1500);
    test_random(2, 800);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
